// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: bus-side target for the cpu core.
// Serves 2 KiB of internal RAM mirrored over $0000-$1FFF, forwards
// $8000-$FFFF to a variable-latency external ROM port, and returns the
// open-bus value for $2000-$7FFF. A request sampled while a ROM read is
// outstanding is parked in a single pending slot; the ROM reply is then
// drained and discarded, and the parked request runs once the ROM is free.
module cpu_bus_responder #(
    parameter int RAM_ADDR_WIDTH = 11
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        bus_strobe_i,
    input  logic [15:0] address_i,
    input  logic [7:0]  data_i,
    input  logic        bus_read_i,
    input  logic        bus_write_i,
    output logic [7:0]  data_o,
    output logic        data_valid_o,
    output logic [14:0] rom_address_o,
    output logic        rom_read_o,
    input  logic [7:0]  rom_data_i,
    input  logic        rom_valid_i
);

    localparam int RAM_DEPTH = 1 << RAM_ADDR_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RAM_RD    = 3'd1,
        ST_ACK       = 3'd2,
        ST_ROM_WAIT  = 3'd3,
        ST_ROM_DRAIN = 3'd4
    } state_t;

    state_t state_r;
    state_t state_next_s;

    logic                      strobe_d_r;
    logic                      sample_s;
    logic                      sample_wr_s;
    logic                      pend_valid_r;
    logic                      pend_wr_r;
    logic [15:0]               pend_addr_r;
    logic [7:0]                pend_data_r;
    logic                      use_pend_s;
    logic                      exec_s;
    logic                      exec_wr_s;
    logic [15:0]               exec_addr_s;
    logic [7:0]                exec_data_s;
    logic                      exec_ram_s;
    logic                      exec_rom_s;
    logic [RAM_ADDR_WIDTH-1:0] ram_idx_s;
    logic                      ram_we_s;
    logic                      ram_re_s;
    logic                      rom_req_s;
    logic                      clr_valid_s;
    logic                      set_valid_s;
    logic                      load_ram_s;
    logic                      load_rom_s;
    logic                      pend_load_s;
    logic                      pend_clear_s;
    logic [7:0]                ram_r [RAM_DEPTH];
    logic [7:0]                ram_q_r;

    // A sample is the edge after the strobe; write wins over read.
    assign sample_wr_s = strobe_d_r & bus_write_i;
    assign sample_s    = strobe_d_r & (bus_write_i | bus_read_i);

    // A live sample always beats the parked request (latest request wins).
    assign use_pend_s  = ~sample_s & pend_valid_r;
    assign exec_addr_s = use_pend_s ? pend_addr_r : address_i;
    assign exec_wr_s   = use_pend_s ? pend_wr_r   : sample_wr_s;
    assign exec_data_s = use_pend_s ? pend_data_r : data_i;

    assign exec_ram_s  = (exec_addr_s[15:13] == 3'b000);
    assign exec_rom_s  = exec_addr_s[15];
    assign ram_idx_s   = exec_addr_s[RAM_ADDR_WIDTH-1:0];

    // Registered strobe marks the sample edge.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            strobe_d_r <= 1'b0;
        end else begin
            strobe_d_r <= bus_strobe_i;
        end
    end

    // FSM state register.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and datapath control; executing a request overrides the per-state default.
    always_comb begin
        state_next_s = state_r;
        exec_s       = 1'b0;
        ram_we_s     = 1'b0;
        ram_re_s     = 1'b0;
        rom_req_s    = 1'b0;
        clr_valid_s  = 1'b0;
        set_valid_s  = 1'b0;
        load_ram_s   = 1'b0;
        load_rom_s   = 1'b0;
        pend_load_s  = 1'b0;
        pend_clear_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                exec_s = sample_s | pend_valid_r;
            end
            ST_RAM_RD: begin
                if (sample_s) begin
                    exec_s = 1'b1;
                end else begin
                    load_ram_s   = 1'b1;
                    set_valid_s  = 1'b1;
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACK: begin
                if (sample_s) begin
                    exec_s = 1'b1;
                end else begin
                    set_valid_s  = 1'b1;
                    state_next_s = ST_IDLE;
                end
            end
            ST_ROM_WAIT: begin
                if (sample_s) begin
                    pend_load_s  = 1'b1;
                    state_next_s = rom_valid_i ? ST_IDLE : ST_ROM_DRAIN;
                end else if (rom_valid_i) begin
                    load_rom_s   = 1'b1;
                    state_next_s = ST_ACK;
                end else begin
                    state_next_s = ST_ROM_WAIT;
                end
            end
            ST_ROM_DRAIN: begin
                pend_load_s  = sample_s;
                state_next_s = rom_valid_i ? ST_IDLE : ST_ROM_DRAIN;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
        if (exec_s) begin
            clr_valid_s  = 1'b1;
            pend_clear_s = 1'b1;
            if (exec_wr_s) begin
                ram_we_s     = exec_ram_s;
                state_next_s = ST_ACK;
            end else if (exec_ram_s) begin
                ram_re_s     = 1'b1;
                state_next_s = ST_RAM_RD;
            end else if (exec_rom_s) begin
                rom_req_s    = 1'b1;
                state_next_s = ST_ROM_WAIT;
            end else begin
                state_next_s = ST_ACK;
            end
        end else begin
            pend_clear_s = 1'b0;
        end
    end

    // Internal RAM: write and synchronous read both happen on the execute edge.
    always_ff @(posedge clock_i) begin
        if (ram_we_s) begin
            ram_r[ram_idx_s] <= exec_data_s;
        end
        if (ram_re_s) begin
            ram_q_r <= ram_r[ram_idx_s];
        end
    end

    // Response outputs; data_o only loads on completed reads, so it doubles as the open-bus register.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            data_o        <= 8'h00;
            data_valid_o  <= 1'b0;
            rom_read_o    <= 1'b0;
            rom_address_o <= 15'h0000;
        end else begin
            rom_read_o <= rom_req_s;
            if (rom_req_s) begin
                rom_address_o <= exec_addr_s[14:0];
            end
            if (load_ram_s) begin
                data_o <= ram_q_r;
            end else if (load_rom_s) begin
                data_o <= rom_data_i;
            end
            if (clr_valid_s) begin
                data_valid_o <= 1'b0;
            end else if (set_valid_s) begin
                data_valid_o <= 1'b1;
            end
        end
    end

    // Single pending slot for a request sampled while the ROM is busy.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            pend_valid_r <= 1'b0;
            pend_wr_r    <= 1'b0;
            pend_addr_r  <= 16'h0000;
            pend_data_r  <= 8'h00;
        end else if (pend_load_s) begin
            pend_valid_r <= 1'b1;
            pend_wr_r    <= sample_wr_s;
            pend_addr_r  <= address_i;
            pend_data_r  <= data_i;
        end else if (pend_clear_s) begin
            pend_valid_r <= 1'b0;
        end
    end

endmodule
